// File: rtl/peripheral_irq_ctrl_pkg.sv
// peripheral_irq_ctrl_pkg: register offsets and FSM encodings shared by the interrupt controller.
package peripheral_irq_ctrl_pkg;
    localparam logic [3:0] IRQ_PENDING = 4'h0;
    localparam logic [3:0] IRQ_MASK    = 4'h2;
    localparam logic [3:0] IRQ_EDGE    = 4'h4;
    localparam logic [3:0] IRQ_CTRL    = 4'h6;
    localparam logic [3:0] IRQ_VECTOR  = 4'h8;
    localparam logic [3:0] IRQ_EOI     = 4'hA;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} irq_state_e;
endpackage

// File: rtl/peripheral_irq_ctrl_prio_enc.sv
// irq_prio_enc: lowest-index-wins priority encoder producing {valid, index}.
module irq_prio_enc #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [3:0]   idx_o
);
    always_comb begin
        valid_o = |req_i;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req_i[i]) idx_o = 4'(i);
    end
endmodule

// File: rtl/peripheral_irq_ctrl.sv
// peripheral_irq_ctrl: pending/mask/edge interrupt controller with fixed priority and I/O-slot bus.
// Optional IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every src_in bit.
module peripheral_irq_ctrl
    import peripheral_irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      d_in,
    input  logic             cs,
    input  logic [3:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [15:0]      d_out,
    input  logic [N_SRC-1:0] src_in,
    output logic             irq,
    input  logic             irq_ack,
    output logic [3:0]       irq_vec
);
    logic [N_SRC-1:0] src_s, prev_q, pend_q, pend_d, mask_q, edge_q, req, w1c, aclr;
    logic             gen_q, ack_q, irq_q, irq_d, win_v, p_rd, p_wr, unused_bits;
    logic [3:0]       vec_q, vec_d, win_idx;
    logic [15:0]      dout_q, dout_d, rdata;
    irq_state_e       state_q, state_d;

`ifdef IRQ_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_in;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = src_in;
`endif

    assign p_rd        = rd & ~ack_q & cs;
    assign p_wr        = wr & ~ack_q & cs;
    assign req         = pend_q & mask_q & {N_SRC{gen_q}};
    assign d_out       = dout_q;
    assign irq         = irq_q;
    assign irq_vec     = vec_q;
    assign unused_bits = ^d_in;

    irq_prio_enc #(.N(N_SRC)) u_prio (.req_i(req), .valid_o(win_v), .idx_o(win_idx));

    // Edge bits keep state and accept clears; a fresh edge overrides a same-cycle clear.
    always_comb begin
        w1c    = (p_wr && addr == IRQ_PENDING) ? d_in[N_SRC-1:0] : '0;
        aclr   = (state_q == REQ && irq_ack) ? N_SRC'(1) << vec_q : '0;
        pend_d = (edge_q & ((pend_q & ~(w1c | aclr)) | (src_s & ~prev_q))) | (~edge_q & src_s);
        rdata  = addr == IRQ_PENDING ? 16'(pend_q) :
                 addr == IRQ_MASK    ? 16'(mask_q) :
                 addr == IRQ_EDGE    ? 16'(edge_q) :
                 addr == IRQ_CTRL    ? {15'd0, gen_q} :
                 addr == IRQ_VECTOR  ? {6'd0, state_q, 4'd0, vec_q} : 16'd0;
        dout_d = p_rd ? rdata : dout_q;
    end

    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: if (win_v) begin
                state_d = REQ;
                irq_d   = 1'b1;
                vec_d   = win_idx;
            end
            REQ: if (irq_ack) begin
                state_d = SERV;
                irq_d   = 1'b0;
            end else if (!win_v) begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
            SERV: if (p_wr && addr == IRQ_EOI) state_d = IDLE;
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
            vec_q   <= '0;
            dout_q  <= '0;
            ack_q   <= 1'b0;
            pend_q  <= '0;
            prev_q  <= '0;
            mask_q  <= '0;
            edge_q  <= '1;
            gen_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
            dout_q  <= dout_d;
            ack_q   <= p_rd | p_wr;
            pend_q  <= pend_d;
            prev_q  <= src_s;
            if (p_wr && addr == IRQ_MASK) mask_q <= d_in[N_SRC-1:0];
            if (p_wr && addr == IRQ_EDGE) edge_q <= d_in[N_SRC-1:0];
            if (p_wr && addr == IRQ_CTRL) gen_q  <= d_in[0];
        end
    end
endmodule

// File: tb/tb_peripheral_irq_ctrl.sv
// tb_peripheral_irq_ctrl: scoreboard bench; expected read data and irq vectors are queued by stimulus.
module tb_peripheral_irq_ctrl;
    logic        clk = 0, reset = 1, cs = 0, rd = 0, wr = 0, irq_ack = 0;
    logic [15:0] d_in = '0;
    logic [3:0]  addr = '0;
    logic [7:0]  src_in = '0;
    logic [15:0] d_out;
    logic        irq;
    logic [3:0]  irq_vec;
    int          n_total = 0, n_pass = 0;
    logic [15:0] rd_exp_q[$], rd_msk_q[$];
    string       rd_name_q[$];
    logic [3:0]  irq_exp_q[$];

    peripheral_irq_ctrl #(.N_SRC(8)) dut (
        .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
        .d_out(d_out), .src_in(src_in), .irq(irq), .irq_ack(irq_ack), .irq_vec(irq_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [15:0] d);
        cs = 1; wr = 1; addr = a; d_in = d;
        tick();
        cs = 0; wr = 0;
        tick();
    endtask

    task automatic rd_reg(input logic [3:0] a, input logic [15:0] exp, input logic [15:0] msk,
                          input string name);
        rd_exp_q.push_back(exp & msk);
        rd_msk_q.push_back(msk);
        rd_name_q.push_back(name);
        cs = 1; rd = 1; addr = a;
        tick();
        cs = 0; rd = 0;
        tick();
    endtask

    task automatic pulse_src(input logic [7:0] v);
        src_in = v;
        tick();
        src_in = '0;
    endtask

    task automatic ack();
        irq_ack = 1;
        tick();
        irq_ack = 0;
    endtask

    // Read monitor: a strobe seen at an edge means d_out is valid by the following negedge.
    initial forever begin
        @(posedge clk);
        if (cs && rd && !reset) begin
            @(negedge clk);
            if (rd_exp_q.size() == 0) chk("unexpected_read", d_out, 16'hxxxx);
            else begin
                logic [15:0] m;
                m = rd_msk_q.pop_front();
                chk(rd_name_q.pop_front(), d_out & m, rd_exp_q.pop_front());
            end
        end
    end

    // Irq monitor: every rising irq must carry the next queued vector.
    initial begin
        logic irq_prev;
        irq_prev = 0;
        forever begin
            @(negedge clk);
            if (irq && !irq_prev) begin
                if (irq_exp_q.size() == 0) chk("unexpected_irq", {12'd0, irq_vec}, 16'hxxxx);
                else chk("irq_vec", {12'd0, irq_vec}, {12'd0, irq_exp_q.pop_front()});
            end
            irq_prev = irq;
        end
    end

    initial begin
        tick(2);
        reset = 0;
        chk("rst_irq", {15'd0, irq}, 16'd0);
        chk("rst_dout", d_out, 16'd0);
        rd_reg(4'h0, 16'h0000, 16'hFFFF, "rst_pending");
        rd_reg(4'h2, 16'h0000, 16'hFFFF, "rst_mask");
        rd_reg(4'h4, 16'h00FF, 16'hFFFF, "rst_edge");
        rd_reg(4'h6, 16'h0000, 16'hFFFF, "rst_ctrl");
        rd_reg(4'h8, 16'h0000, 16'hFFFF, "rst_vector");
        rd_reg(4'hC, 16'h0000, 16'hFFFF, "unmapped_read");

        wr_reg(4'h2, 16'h0001);
        wr_reg(4'h6, 16'h0001);
        irq_exp_q.push_back(4'd0);
        pulse_src(8'h01);
        tick();
        chk("t1_irq_2cyc", {15'd0, irq}, 16'd1);
        rd_reg(4'h0, 16'h0001, 16'hFFFF, "t1_pending");
        rd_reg(4'h8, 16'h0100, 16'hFFFF, "t1_vector_req");
        ack();
        rd_reg(4'h0, 16'h0000, 16'hFFFF, "t1_autoclr");
        rd_reg(4'h8, 16'h0200, 16'hFFFF, "t1_vector_serv");
        wr_reg(4'hA, 16'h0000);
        rd_reg(4'h8, 16'h0000, 16'hFFFF, "t1_vector_idle");

        wr_reg(4'h2, 16'h00FF);
        irq_exp_q.push_back(4'd2);
        irq_exp_q.push_back(4'd5);
        pulse_src(8'h24);
        tick();
        rd_reg(4'h8, 16'h0102, 16'hFFFF, "t2_vector_2");
        ack();
        rd_reg(4'h0, 16'h0020, 16'hFFFF, "t2_pending_5");
        wr_reg(4'hA, 16'h1234);
        rd_reg(4'h8, 16'h0105, 16'hFFFF, "t2_vector_5");
        ack();
        wr_reg(4'hA, 16'h0000);
        rd_reg(4'h0, 16'h0000, 16'hFFFF, "t2_pending_empty");

        wr_reg(4'h2, 16'h0000);
        pulse_src(8'h08);
        tick();
        rd_reg(4'h0, 16'h0008, 16'hFFFF, "t3_pending_masked");
        chk("t3_irq_masked", {15'd0, irq}, 16'd0);
        irq_exp_q.push_back(4'd3);
        wr_reg(4'h2, 16'h0008);
        chk("t3_irq_unmasked", {15'd0, irq}, 16'd1);
        rd_reg(4'h8, 16'h0103, 16'hFFFF, "t3_vector");

        wr_reg(4'h0, 16'h0008);
        chk("t4_irq_dropped", {15'd0, irq}, 16'd0);
        rd_reg(4'h8, 16'h0000, 16'h0300, "t4_state_idle");
        rd_reg(4'h0, 16'h0000, 16'hFFFF, "t4_pending");

        wr_reg(4'h4, 16'h00FD);
        wr_reg(4'h2, 16'h0002);
        irq_exp_q.push_back(4'd1);
        irq_exp_q.push_back(4'd1);
        src_in = 8'h02;
        tick(2);
        ack();
        rd_reg(4'h0, 16'h0002, 16'hFFFF, "t5_level_pending");
        wr_reg(4'h0, 16'h0002);
        rd_reg(4'h0, 16'h0002, 16'hFFFF, "t5_level_w1c_ignored");
        wr_reg(4'hA, 16'h0000);
        chk("t5_irq_reassert", {15'd0, irq}, 16'd1);
        src_in = 8'h00;
        tick(2);
        rd_reg(4'h0, 16'h0000, 16'hFFFF, "t5_level_drop");
        chk("t5_irq_after_drop", {15'd0, irq}, 16'd0);

        wr_reg(4'h4, 16'h00FF);
        wr_reg(4'h2, 16'h0001);
        irq_exp_q.push_back(4'd0);
        pulse_src(8'h01);
        tick();
        ack();
        rd_reg(4'h8, 16'h0200, 16'hFFFF, "t6_in_serv");
        reset = 1;
        tick();
        reset = 0;
        chk("t6_rst_irq", {15'd0, irq}, 16'd0);
        chk("t6_rst_dout", d_out, 16'd0);
        rd_reg(4'h2, 16'h0000, 16'hFFFF, "t6_rst_mask");
        rd_reg(4'h4, 16'h00FF, 16'hFFFF, "t6_rst_edge");
        rd_reg(4'h6, 16'h0000, 16'hFFFF, "t6_rst_ctrl");
        rd_reg(4'h8, 16'h0000, 16'hFFFF, "t6_rst_vector");
        wr_reg(4'h2, 16'h0010);
        wr_reg(4'h6, 16'h0001);
        irq_exp_q.push_back(4'd4);
        pulse_src(8'h10);
        tick();
        rd_reg(4'h8, 16'h0104, 16'hFFFF, "t6_new_event");
        ack();
        wr_reg(4'hA, 16'h0000);

        tick(5);
        chk("irq_queue_drained", 16'(irq_exp_q.size()), 16'd0);
        chk("read_queue_drained", 16'(rd_exp_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
